// File: rtl/trading_pkg.sv
// Shared types and widths for the trading pipeline blocks.
package trading_pkg;
    localparam int PRICE_W = 16;
    localparam int PNL_W   = 32;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    typedef enum logic [1:0] {
        FLAT = 2'd0,
        LONG = 2'd1,
        SEND = 2'd2,
        COOL = 2'd3
    } state_t;
endpackage

// File: rtl/pnl_accum.sv
// Registered signed accumulation of (exit - entry) on each closed trade.
module pnl_accum
    import trading_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [PRICE_W-1:0] i_entry,
    input  logic [PRICE_W-1:0] i_exit,
    output logic [PNL_W-1:0]   o_pnl
);
    logic [PRICE_W:0] w_diff;
    logic [PNL_W-1:0] w_diff_ext;
    logic [PNL_W-1:0] r_pnl;

    // 17-bit two's complement difference, sign-extended; the sum wraps mod 2^32
    assign w_diff     = {1'b0, i_exit} - {1'b0, i_entry};
    assign w_diff_ext = {{(PNL_W-PRICE_W-1){w_diff[PRICE_W]}}, w_diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_pnl <= '0;
        else if (i_en) r_pnl <= r_pnl + w_diff_ext;
    end

    assign o_pnl = r_pnl;
endmodule

// File: rtl/order_executor.sv
// Turns buy/sell decisions into handshaked long-only market orders with cooldown.
// Optional order abandonment after TIMEOUT_CYCLES when ORDER_TIMEOUT_EN is defined.
module order_executor
    import trading_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               buy,
    input  logic               sell,
    input  logic [PRICE_W-1:0] price_now,
    output logic               order_valid,
    input  logic               order_ready,
    output logic               order_side,
    output logic [PRICE_W-1:0] order_price,
    output logic               position,
    output logic [PRICE_W-1:0] entry_price,
    output logic [PNL_W-1:0]   realized_pnl,
    output logic [15:0]        trade_count,
    output logic               busy,
    output logic               order_timeout
);
    localparam int CW = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cool;
    logic               r_side, r_pos;
    logic [PRICE_W-1:0] r_price, r_entry;
    logic [15:0]        r_count;
    logic               w_hs, w_tmo, w_launch, w_side_nxt;
    state_t             w_home;

    assign w_hs   = (r_state == SEND) && order_ready;
    assign w_home = r_pos ? LONG : FLAT;

`ifdef ORDER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;
    logic          r_tmo;

    assign w_tmo = (r_state == SEND) && !order_ready && (r_wait == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_wait <= (r_state == SEND) ? r_wait + 1'b1 : '0;
            r_tmo  <= w_tmo;
        end
    end

    assign order_timeout = r_tmo;
`else
    assign w_tmo         = 1'b0;
    assign order_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_side_nxt  = r_side;
        case (r_state)
            FLAT: if (buy && !sell) begin
                w_state_nxt = SEND;
                w_launch    = 1'b1;
                w_side_nxt  = SIDE_BUY;
            end
            LONG: if (sell && !buy) begin
                w_state_nxt = SEND;
                w_launch    = 1'b1;
                w_side_nxt  = SIDE_SELL;
            end
            SEND: begin
                if (w_hs) begin
                    if (COOLDOWN_CYCLES == 0)
                        w_state_nxt = (r_side == SIDE_BUY) ? LONG : FLAT;
                    else
                        w_state_nxt = COOL;
                end else if (w_tmo) begin
                    w_state_nxt = w_home;
                end
            end
            COOL: if (r_cool <= CW'(1)) w_state_nxt = w_home;
            default: w_state_nxt = FLAT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FLAT;
            r_cool  <= '0;
            r_side  <= 1'b0;
            r_price <= '0;
            r_pos   <= 1'b0;
            r_entry <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_side  <= w_side_nxt;
                r_price <= price_now;
            end
            if (w_hs) begin
                r_cool <= CW'(COOLDOWN_CYCLES);
                r_pos  <= (r_side == SIDE_BUY);
                if (r_side == SIDE_BUY) r_entry <= r_price;
                if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            end else if (r_state == COOL) begin
                r_cool <= r_cool - CW'(1);
            end
        end
    end

    pnl_accum u_pnl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_hs && (r_side == SIDE_SELL)),
        .i_entry (r_entry),
        .i_exit  (r_price),
        .o_pnl   (realized_pnl)
    );

    assign order_valid = (r_state == SEND);
    assign busy        = (r_state == SEND) || (r_state == COOL);
    assign order_side  = r_side;
    assign order_price = r_price;
    assign position    = r_pos;
    assign entry_price = r_entry;
    assign trade_count = r_count;
endmodule

// File: tb/tb_order_executor.sv
// Directed bench for order_executor; the timeout scenario runs when ORDER_TIMEOUT_EN is defined.
module tb_order_executor;
    localparam int CD = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        buy = 1'b0, sell = 1'b0, order_ready = 1'b0;
    logic [15:0] price_now = '0;
    logic        order_valid, order_side, position, busy, order_timeout;
    logic [15:0] order_price, entry_price, trade_count;
    logic [31:0] realized_pnl;

    int checks = 0;
    int errors = 0;

    order_executor #(.COOLDOWN_CYCLES(CD), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buy           (buy),
        .sell          (sell),
        .price_now     (price_now),
        .order_valid   (order_valid),
        .order_ready   (order_ready),
        .order_side    (order_side),
        .order_price   (order_price),
        .position      (position),
        .entry_price   (entry_price),
        .realized_pnl  (realized_pnl),
        .trade_count   (trade_count),
        .busy          (busy),
        .order_timeout (order_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({order_valid, order_side, order_price, position, entry_price, realized_pnl,
             trade_count, busy, order_timeout} !== 85'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%b p=%0d pos=%b e=%0d pnl=%h cnt=%0d busy=%b to=%b, want all 0",
                     order_valid, order_side, order_price, position, entry_price, realized_pnl,
                     trade_count, busy, order_timeout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({order_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b busy=%b, want 0 0", order_valid, busy);
        end
    endtask

    task automatic test_buy_open;
        buy = 1'b1; price_now = 16'd100; order_ready = 1'b1;
        tick();
        checks++;
        if ({order_valid, order_side, order_price} !== {1'b1, 1'b1, 16'd100}) begin
            errors++;
            $display("FAIL buy_order: got v=%b s=%b p=%0d, want 1 1 100", order_valid, order_side, order_price);
        end
        buy = 1'b0;
        tick();
        checks++;
        if ({order_valid, position, entry_price, trade_count, busy} !== {1'b0, 1'b1, 16'd100, 16'd1, 1'b1}) begin
            errors++;
            $display("FAIL buy_accept: got v=%b pos=%b e=%0d cnt=%0d busy=%b, want 0 1 100 1 1",
                     order_valid, position, entry_price, trade_count, busy);
        end
    endtask

    task automatic test_cooldown_sell;
        price_now = 16'd130;
        for (int i = 1; i <= CD; i++) begin
            buy = i[0];
            sell = 1'b1;
            tick();
            checks++;
            if (order_valid !== 1'b0) begin
                errors++;
                $display("FAIL cooldown_quiet[%0d]: got valid=%b, want 0", i, order_valid);
            end
        end
        buy = 1'b0; sell = 1'b1;
        tick();
        checks++;
        if ({order_valid, order_side, order_price} !== {1'b1, 1'b0, 16'd130}) begin
            errors++;
            $display("FAIL sell_after_cooldown: got v=%b s=%b p=%0d, want 1 0 130", order_valid, order_side, order_price);
        end
        sell = 1'b0;
        tick();
        checks++;
        if ({order_valid, position, realized_pnl, trade_count} !== {1'b0, 1'b0, 32'd30, 16'd2}) begin
            errors++;
            $display("FAIL sell_profit: got v=%b pos=%b pnl=%h cnt=%0d, want 0 0 0000001e 2",
                     order_valid, position, realized_pnl, trade_count);
        end
        repeat (CD) tick();
    endtask

    task automatic test_loss_stall;
        buy = 1'b1; price_now = 16'd200; order_ready = 1'b1;
        tick();
        buy = 1'b0;
        tick();
        checks++;
        if ({position, entry_price, trade_count} !== {1'b1, 16'd200, 16'd3}) begin
            errors++;
            $display("FAIL rebuy: got pos=%b e=%0d cnt=%0d, want 1 200 3", position, entry_price, trade_count);
        end
        repeat (CD) tick();
        sell = 1'b1; price_now = 16'd150; order_ready = 1'b0;
        tick();
        checks++;
        if ({order_valid, order_side, order_price} !== {1'b1, 1'b0, 16'd150}) begin
            errors++;
            $display("FAIL stall_launch: got v=%b s=%b p=%0d, want 1 0 150", order_valid, order_side, order_price);
        end
        for (int i = 1; i <= 5; i++) begin
            sell = i[0];
            buy = i[1];
            price_now = 16'(300 + i);
            tick();
            checks++;
            if ({order_valid, order_side, order_price, position} !== {1'b1, 1'b0, 16'd150, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%b p=%0d pos=%b, want 1 0 150 1",
                         i, order_valid, order_side, order_price, position);
            end
        end
        buy = 1'b0; sell = 1'b0; order_ready = 1'b1;
        tick();
        checks++;
        if ({order_valid, position, realized_pnl, trade_count} !== {1'b0, 1'b0, 32'hFFFF_FFEC, 16'd4}) begin
            errors++;
            $display("FAIL loss_pnl: got v=%b pos=%b pnl=%h cnt=%0d, want 0 0 ffffffec 4",
                     order_valid, position, realized_pnl, trade_count);
        end
        repeat (CD) tick();
    endtask

    task automatic test_ignored;
        for (int i = 0; i < 6; i++) begin
            buy = (i < 3);
            sell = 1'b1;
            price_now = 16'(40 + i);
            tick();
            checks++;
            if ({order_valid, busy, position, trade_count} !== {1'b0, 1'b0, 1'b0, 16'd4}) begin
                errors++;
                $display("FAIL ignored[%0d]: got v=%b busy=%b pos=%b cnt=%0d, want 0 0 0 4",
                         i, order_valid, busy, position, trade_count);
            end
        end
        buy = 1'b0; sell = 1'b0;
    endtask

    task automatic test_reset_mid_send;
        buy = 1'b1; price_now = 16'd77; order_ready = 1'b0;
        tick();
        buy = 1'b0;
        checks++;
        if (order_valid !== 1'b1) begin
            errors++;
            $display("FAIL midsend_launch: got valid=%b, want 1", order_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({order_valid, order_side, order_price, position, entry_price, realized_pnl,
             trade_count, busy} !== 84'd0) begin
            errors++;
            $display("FAIL midsend_reset: got v=%b s=%b p=%0d pos=%b e=%0d pnl=%h cnt=%0d busy=%b, want all 0",
                     order_valid, order_side, order_price, position, entry_price, realized_pnl,
                     trade_count, busy);
        end
        order_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({order_valid, busy, trade_count} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b busy=%b cnt=%0d, want 0 0 0", order_valid, busy, trade_count);
        end
    endtask

`ifdef ORDER_TIMEOUT_EN
    task automatic test_timeout;
        buy = 1'b1; price_now = 16'd90; order_ready = 1'b0;
        tick();
        buy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({order_valid, order_timeout} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got v=%b to=%b, want 1 0", k, order_valid, order_timeout);
            end
            tick();
        end
        checks++;
        if ({order_valid, order_timeout, busy, position, trade_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL timeout_pulse: got v=%b to=%b busy=%b pos=%b cnt=%0d, want 0 1 0 0 0",
                     order_valid, order_timeout, busy, position, trade_count);
        end
        tick();
        checks++;
        if (order_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single: got to=%b, want 0", order_timeout);
        end
    endtask
`else
    task automatic test_timeout;
        buy = 1'b1; price_now = 16'd90; order_ready = 1'b0;
        tick();
        buy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({order_valid, order_timeout} !== 2'b10) begin
                errors++;
                $display("FAIL no_timeout[%0d]: got v=%b to=%b, want 1 0", k, order_valid, order_timeout);
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_buy_open();
        test_cooldown_sell();
        test_loss_stall();
        test_ignored();
        test_reset_mid_send();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/order_executor.md
# order_executor

Consumes the registered buy/sell decision signals of the trading pipeline and turns them into single, handshaked market orders. Tracks a long-only position (flat or long one unit), the entry price, realized profit/loss and a trade counter. Enforces a post-trade cooldown so bursts of decisions cannot cause order churn. Sits directly downstream of the decision stage and upstream of any order sink (UART, host bridge, testbench monitor).

## Interface
- COOLDOWN_CYCLES, 16: cycles after an accepted order during which decisions are ignored; 0 = none
- TIMEOUT_CYCLES, 1024: max cycles an order waits for acceptance (used only with ORDER_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- buy  in  1  buy decision, level, sampled every cycle
- sell  in  1  sell decision, level, sampled every cycle
- price_now  in  16  unsigned current price
- order_valid  out  1  order offered to sink
- order_ready  in  1  sink accepts order when high with order_valid
- order_side  out  1  1 = BUY, 0 = SELL; stable while order_valid
- order_price  out  16  price latched at decision; stable while order_valid
- position  out  1  1 = long, 0 = flat
- entry_price  out  16  price of the open long; holds the last value when flat
- realized_pnl  out  32  signed accumulated profit/loss
- trade_count  out  16  accepted orders, saturating at 0xFFFF
- busy  out  1  high in SEND or COOL
- order_timeout  out  1  one-cycle pulse when an order is abandoned

## Operation
- States: FLAT, LONG, SEND, COOL. Reset state is FLAT.
- Reset values: all outputs 0, including order_side, order_price, entry_price, realized_pnl and trade_count.
- FLAT:
  - buy=1 and sell=0: latch price_now into order_price, set order_side=1, go to SEND.
  - sell alone is ignored (no shorting).
- LONG:
  - sell=1 and buy=0: latch price, set order_side=0, go to SEND.
  - buy alone is ignored (no pyramiding).
- buy=1 and sell=1 in the same cycle: ignored in every state.
- SEND:
  - order_valid=1. order_side and order_price are held stable until the handshake.
  - buy, sell and price_now are ignored.
- Handshake (order_valid and order_ready):
  - BUY: position<=1, entry_price<=order_price.
  - SELL: position<=0, realized_pnl <= realized_pnl + sign-extended (order_price - entry_price). The difference is 17-bit signed; accumulation wraps modulo 2^32.
  - In both cases trade_count increments, saturating at 0xFFFF.
  - Next state: COOL with the counter loaded to COOLDOWN_CYCLES. If COOLDOWN_CYCLES=0, go directly to LONG or FLAT according to the new position.
- COOL:
  - The counter decrements each cycle; decisions are ignored.
  - When the counter reaches 1, the next state is LONG or FLAT according to position.
- busy = (state==SEND) or (state==COOL).

## Timing
- Decision sampled at edge N: order_valid high from N+1.
- order_ready may already be high at N+1; the handshake then completes in that cycle, giving a minimum occupancy of SEND for one cycle.
- Handshake at edge M:
  - order_valid low, and position, entry_price, realized_pnl and trade_count updated, all visible after M.
  - The first cycle in which a new decision is sampled is M+COOLDOWN_CYCLES+1.
- Decision-to-order latency is 1 cycle; the block has no combinational path from inputs to outputs.
- rst_n asserted mid-SEND or mid-COOL: everything returns immediately to reset values and the pending order is dropped. order_valid is low while rst_n is low.

## Configuration
- ORDER_TIMEOUT_EN defined:
  - A wait counter runs in SEND.
  - If TIMEOUT_CYCLES cycles elapse without a handshake: order_valid drops, order_timeout pulses for one cycle, the state returns to the pre-SEND state (FLAT or LONG), and no position, pnl or count update occurs. There is no cooldown.
- ORDER_TIMEOUT_EN not defined: SEND waits indefinitely and order_timeout is tied 0.

## Structure
- Shared package trading_pkg holds:
  - the state enum (FLAT, LONG, SEND, COOL)
  - SIDE_BUY=1 / SIDE_SELL=0
  - PRICE_W=16, PNL_W=32
- One sub-module, pnl_accum:
  - inputs: entry price, exit price, enable
  - function: registered signed accumulation
  - output: realized_pnl

## Test plan
- Reset, then buy=1, price_now=100, order_ready=1 -> order_valid for 1 cycle with side=1, price=100; position=1, entry_price=100, trade_count=1.
- Long at 100, sell with price_now=130 after cooldown -> side=0, price=130; realized_pnl=+30, position=0. Repeat with buy at 200 and sell at 150 -> realized_pnl=-20 (0xFFFFFFEC).
- COOLDOWN_CYCLES=16: keep buy and sell toggling right after the handshake -> no order for 16 cycles; the first sell is honored exactly on the cycle after cooldown ends.
- Hold order_ready=0 for 5 cycles while price_now and decisions change -> order_valid, order_side and order_price stay stable; acceptance happens on cycle 6.
- buy=sell=1 in FLAT, and sell alone in FLAT -> no order_valid, no state change. Assert rst_n low during SEND -> order_valid=0 immediately and all outputs return to 0.
- With ORDER_TIMEOUT_EN and TIMEOUT_CYCLES=8, order_ready=0 -> order_timeout pulses 8 cycles after order_valid rises; position and trade_count are unchanged.
